disp_frame_sched: RTL and testbench

Display frame scheduler between the game control logic and the seven-segment driver. It accepts timed display frames from two requesters, such as the game state machine and the AI-reveal/score logic. Frames are arbitrated round-robin into a small queue, and each frame is held on the display for a requested number of timer ticks. When the queue is empty, the block falls back to a live frame. It replaces the ad-hoc pause counter with a handshake-driven, queue-backed display path feeding the SevenSegmentLED `C_In`.

---
 rtl/disp_pkg.sv | 39 +++
 rtl/frame_fifo.sv | 58 +++++
 rtl/disp_frame_sched.sv | 159 +++++++++++++++
 tb/tb_disp_frame_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the display frame scheduler.
// Frame width, seven-segment glyphs and scheduler state encoding.
package disp_pkg;

  localparam int FRAME_W = 56;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_H     = 7'h76;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_U     = 7'h3E;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_N     = 7'h54;
  localparam logic [6:0] SEG_O     = 7'h5C;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } sched_state_t;

endpackage

// File: rtl/frame_fifo.sv
// frame_fifo: DEPTH-entry first-word-fall-through queue of frame+hold.
// Head entry is always visible on o_rdata; flush empties it in one edge.
module frame_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 60
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/disp_frame_sched.sv
// disp_frame_sched: round-robin queued frame scheduler for the 7-seg path.
// Build option DISP_SCHED_SKIP_EN lets SKIP end a hold early.
module disp_frame_sched #(
  parameter int DEPTH   = 4,
  parameter int HOLD_W  = 4,
  parameter int FRAME_W = disp_pkg::FRAME_W
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         TICK,
  input  logic [FRAME_W-1:0]           LIVE_FRAME,
  input  logic                         A_VALID,
  input  logic [FRAME_W-1:0]           A_FRAME,
  input  logic [HOLD_W-1:0]            A_HOLD,
  output logic                         A_READY,
  input  logic                         B_VALID,
  input  logic [FRAME_W-1:0]           B_FRAME,
  input  logic [HOLD_W-1:0]            B_HOLD,
  output logic                         B_READY,
  input  logic                         FLUSH,
  input  logic                         SKIP,
  output logic [FRAME_W-1:0]           DISP_In,
  output logic                         BUSY,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT
);

  import disp_pkg::*;

  localparam int EW = FRAME_W + HOLD_W;

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;
  logic                r_ptr;
  logic [FRAME_W-1:0]  r_disp;
  logic [FRAME_W-1:0]  w_disp_nxt;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic [HOLD_W-1:0]   r_tcnt;
  logic [HOLD_W-1:0]   w_tcnt_nxt;

  logic                w_full;
  logic                w_empty;
  logic [EW-1:0]       w_head;
  logic [EW-1:0]       w_wdata;
  logic [HOLD_W-1:0]   w_head_hold;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_push_a;
  logic                w_push_b;
  logic                w_push;
  logic                w_pop;
  logic                w_skip;
  logic                w_expire;

`ifdef DISP_SCHED_SKIP_EN
  assign w_skip = SKIP;
`else
  logic w_unused_skip;
  assign w_unused_skip = SKIP;
  assign w_skip = 1'b0;
`endif

  assign w_grant_a = A_VALID && (!B_VALID || !r_ptr);
  assign w_grant_b = B_VALID && (!A_VALID || r_ptr);
  assign A_READY   = RST_N && !w_full && !FLUSH && w_grant_a;
  assign B_READY   = RST_N && !w_full && !FLUSH && w_grant_b;
  assign w_push_a  = A_VALID && A_READY;
  assign w_push_b  = B_VALID && B_READY;
  assign w_push    = w_push_a || w_push_b;
  assign w_wdata   = w_push_a ? {A_HOLD, A_FRAME} : {B_HOLD, B_FRAME};
  assign w_head_hold = w_head[EW-1:FRAME_W];

  assign DISP_In = r_disp;
  assign BUSY    = (r_state == ST_SHOW) || !w_empty;

  frame_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_flush (FLUSH),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (COUNT)
  );

  // round-robin pointer flips away from whoever just pushed
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        r_ptr <= 1'b0;
    else if (w_push_a) r_ptr <= 1'b1;
    else if (w_push_b) r_ptr <= 1'b0;
  end

  // state, display and hold registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_disp  <= '0;
      r_hold  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_disp  <= w_disp_nxt;
      r_hold  <= w_hold_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  // next state: flush first, then pop/expire handling
  always_comb begin
    w_state_nxt = r_state;
    w_disp_nxt  = r_disp;
    w_hold_nxt  = r_hold;
    w_tcnt_nxt  = r_tcnt;
    w_pop       = 1'b0;
    w_expire    = (TICK && (r_tcnt == r_hold - HOLD_W'(1))) || w_skip;
    if (FLUSH) begin
      w_state_nxt = ST_IDLE;
      w_disp_nxt  = LIVE_FRAME;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_disp_nxt = LIVE_FRAME;
          end
        end
        ST_SHOW: begin
          if (w_expire) begin
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_disp_nxt  = LIVE_FRAME;
            end
          end else if (TICK) begin
            w_tcnt_nxt = r_tcnt + HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
      if (w_pop) begin
        w_state_nxt = ST_SHOW;
        w_disp_nxt  = w_head[FRAME_W-1:0];
        w_hold_nxt  = (w_head_hold == '0) ? HOLD_W'(1) : w_head_hold;
        w_tcnt_nxt  = '0;
      end
    end
  end

endmodule

// File: tb/tb_disp_frame_sched.sv
// tb_disp_frame_sched: directed checks of the display frame scheduler.
// Linear stimulus with immediate assertions at each comparison.
module tb_disp_frame_sched;

  localparam int FW    = 56;
  localparam int HW    = 4;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          TICK = 1'b0;
  logic          FLUSH = 1'b0;
  logic          SKIP = 1'b0;
  logic          A_VALID = 1'b0;
  logic          B_VALID = 1'b0;
  logic [FW-1:0] LIVE_FRAME = '0;
  logic [FW-1:0] A_FRAME = '0;
  logic [FW-1:0] B_FRAME = '0;
  logic [HW-1:0] A_HOLD = '0;
  logic [HW-1:0] B_HOLD = '0;
  logic          A_READY;
  logic          B_READY;
  logic          BUSY;
  logic [FW-1:0] DISP_In;
  logic [2:0]    COUNT;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  disp_frame_sched #(
    .DEPTH   (DEPTH),
    .HOLD_W  (HW),
    .FRAME_W (FW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .TICK       (TICK),
    .LIVE_FRAME (LIVE_FRAME),
    .A_VALID    (A_VALID),
    .A_FRAME    (A_FRAME),
    .A_HOLD     (A_HOLD),
    .A_READY    (A_READY),
    .B_VALID    (B_VALID),
    .B_FRAME    (B_FRAME),
    .B_HOLD     (B_HOLD),
    .B_READY    (B_READY),
    .FLUSH      (FLUSH),
    .SKIP       (SKIP),
    .DISP_In    (DISP_In),
    .BUSY       (BUSY),
    .COUNT      (COUNT)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_step();
    repeat (3) step();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
  endtask

  initial begin
    logic [1:0][4:0] ctn_rdy;
    logic [4:0]      ctn_a;
    logic [2:0]      ctn_cnt [5];
    logic [7:0]      ctn_disp [5];
    ctn_a       = 5'b10101;
    ctn_cnt     = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    ctn_disp    = '{8'h20, 8'h10, 8'h20, 8'h10, 8'h01};
    ctn_rdy     = '0;

    // reset state, ready forced low
    A_VALID = 1'b1;
    #2;
    chk("rst_disp", DISP_In, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_ardy", A_READY, 0);
    step();
    A_VALID = 1'b0;
    LIVE_FRAME = 1;
    RST_N = 1'b1;
    step();
    chk("live_lat", DISP_In, 1);

    // single frame, hold 3
    A_VALID = 1'b1;
    A_FRAME = 'hAA;
    A_HOLD  = 3;
    #1;
    chk("s_ardy", A_READY, 1);
    step();
    A_VALID = 1'b0;
    chk("s_cnt1", COUNT, 1);
    chk("s_live", DISP_In, 1);
    chk("s_busy0", BUSY, 1);
    step();
    chk("s_show", DISP_In, 'hAA);
    chk("s_cnt0", COUNT, 0);
    chk("s_busy1", BUSY, 1);
    tick_step();
    chk("s_t1", DISP_In, 'hAA);
    tick_step();
    chk("s_t2", DISP_In, 'hAA);
    tick_step();
    chk("s_t3", DISP_In, 1);
    chk("s_idle", BUSY, 0);

    // hold zero acts as one tick
    B_VALID = 1'b1;
    B_FRAME = 'h30;
    B_HOLD  = 0;
    #1;
    chk("h0_brdy", B_READY, 1);
    step();
    B_VALID = 1'b0;
    step();
    chk("h0_show", DISP_In, 'h30);
    tick_step();
    chk("h0_end", DISP_In, 1);
    chk("h0_busy", BUSY, 0);

    // contention: alternate grants until full
    A_FRAME = 'h10;
    A_HOLD  = 1;
    B_FRAME = 'h20;
    B_HOLD  = 1;
    A_VALID = 1'b1;
    B_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("c_ardy", A_READY, ctn_a[4-i]);
      chk("c_brdy", B_READY, !ctn_a[4-i]);
      step();
      chk("c_cnt", COUNT, ctn_cnt[i]);
      if (i == 1) chk("c_first", DISP_In, 'h10);
    end
    #1;
    chk("c_full_a", A_READY, 0);
    chk("c_full_b", B_READY, 0);
    TICK = 1'b1;
    #1;
    chk("c_fpop_a", A_READY, 0);
    chk("c_fpop_b", B_READY, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        A_VALID = 1'b0;
        B_VALID = 1'b0;
      end
      chk("c_disp", DISP_In, ctn_disp[i]);
    end
    TICK = 1'b0;
    chk("c_busy", BUSY, 0);
    chk("c_cnt0", COUNT, 0);

    // flush with three queued and SHOW mid-hold
    for (int i = 0; i < 4; i++) begin
      A_VALID = 1'b1;
      A_FRAME = FW'('h41 + i);
      A_HOLD  = 5;
      step();
    end
    A_VALID = 1'b0;
    chk("f_cnt3", COUNT, 3);
    chk("f_show", DISP_In, 'h41);
    tick_step();
    chk("f_mid", DISP_In, 'h41);
    LIVE_FRAME = 'h55;
    A_VALID = 1'b1;
    A_FRAME = 'h99;
    FLUSH = 1'b1;
    #1;
    chk("f_ardy", A_READY, 0);
    step();
    chk("f_cnt0", COUNT, 0);
    chk("f_live", DISP_In, 'h55);
    chk("f_busy", BUSY, 0);
    FLUSH = 1'b0;
    A_VALID = 1'b0;
    step();
    chk("f_stay", DISP_In, 'h55);

    // reset during SHOW with two queued
    LIVE_FRAME = 1;
    for (int i = 0; i < 3; i++) begin
      A_VALID = 1'b1;
      A_FRAME = FW'('h61 + i);
      A_HOLD  = 9;
      step();
    end
    A_VALID = 1'b0;
    chk("r_cnt2", COUNT, 2);
    chk("r_show", DISP_In, 'h61);
    A_VALID = 1'b1;
    B_VALID = 1'b1;
    A_FRAME = 'h71;
    B_FRAME = 'h72;
    A_HOLD  = 1;
    B_HOLD  = 1;
    #2;
    RST_N = 1'b0;
    #1;
    chk("r_disp", DISP_In, 0);
    chk("r_busy", BUSY, 0);
    chk("r_cnt", COUNT, 0);
    chk("r_ardy", A_READY, 0);
    chk("r_brdy", B_READY, 0);
    step();
    RST_N = 1'b1;
    #1;
    chk("r_ptr_a", A_READY, 1);
    chk("r_ptr_b", B_READY, 0);
    step();
    chk("r_push", COUNT, 1);
    #1;
    chk("r_next_b", B_READY, 1);
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    step();
    chk("r_disp71", DISP_In, 'h71);
    tick_step();
    chk("r_done", DISP_In, 1);

    // skip pulse after two ticks of a hold-15 frame
    A_VALID = 1'b1;
    A_FRAME = 'h81;
    A_HOLD  = 15;
    step();
    A_FRAME = 'h82;
    step();
    A_VALID = 1'b0;
    chk("k_show", DISP_In, 'h81);
    chk("k_cnt", COUNT, 1);
    tick_step();
    tick_step();
    chk("k_t2", DISP_In, 'h81);
    SKIP = 1'b1;
    step();
    SKIP = 1'b0;
`ifdef DISP_SCHED_SKIP_EN
    chk("k_skip", DISP_In, 'h82);
    chk("k_cnt0", COUNT, 0);
`else
    chk("k_noskip", DISP_In, 'h81);
    chk("k_cnt1", COUNT, 1);
    repeat (12) tick_step();
    chk("k_t14", DISP_In, 'h81);
    tick_step();
    chk("k_t15", DISP_In, 'h82);
    chk("k_cnt0", COUNT, 0);
`endif
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("k_flush", DISP_In, 1);
    chk("k_busy", BUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
